sd_resp_rx: RTL
===============

# sd_resp_rx

Serial-to-parallel receiver for 48-bit SD responses (R1/R3/R6/R7 format) on the card CMD line. It pairs with the host-side parallel-to-serial transmit path and sits between the SD CMD pin synchronizer and the SD command controller. Bits are captured MSB first on each `shift_enable` strobe. The block checks framing and CRC7, enforces the NCR response timeout, and presents the command index and 32-bit payload with a one-cycle valid pulse.

## Interface
- `TIMEOUT`, default 64: maximum number of strobes in WAIT_START before a timeout is flagged.
- `CHECK_CRC`, default 1: when 0, `crc_error` is held at 0. Use 0 for R3, which carries no valid CRC.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: single-cycle request to start listening for a response.
- `shift_enable` in 1: bit strobe; `serial_in` is sampled only in cycles where this is 1.
- `serial_in` in 1: CMD line, already synchronized; idles high.
- `busy` out 1: high in any state other than IDLE.
- `rx_valid` out 1: one-cycle pulse when a frame completes.
- `cmd_index` out 6: bits [45:40] of the frame.
- `payload` out 32: bits [39:8] of the frame.
- `crc_error` out 1: qualified by `rx_valid`; received CRC7 differs from computed CRC7.
- `frame_error` out 1: qualified by `rx_valid`; transmission bit is not 0 or end bit is not 1.
- `timeout` out 1: one-cycle pulse when no start bit arrives within `TIMEOUT` strobes.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE:
  - `arm`=1 moves to WAIT_START and clears the strobe counter.
  - Strobes are ignored in IDLE.
- WAIT_START:
  - Each strobe increments the counter.
  - A strobe sampling 0 is the start bit (frame bit 47): move to RECEIVE, set bit counter to 46, reset CRC to 0, and feed the 0 into the CRC.
  - If `TIMEOUT` strobes sample 1, assert `timeout` for one cycle and return to IDLE.
- RECEIVE:
  - Each strobe shifts `serial_in` into a 47-bit shift register and decrements the bit counter.
  - Bits 46..8 feed the CRC7 (x^7+x^3+1). Bits 7..1 are the received CRC. Bit 0 is the end bit.
  - The strobe that samples bit 0 moves the FSM to DONE.
- DONE (one cycle):
  - `rx_valid`=1; `cmd_index`, `payload`, `crc_error` and `frame_error` are updated.
  - Next state is IDLE.
- `arm` while `busy`=1 is ignored; no restart and no error.
- `cmd_index` and `payload` hold their last values until the next DONE.
- Reset: all state and counters clear; FSM goes to IDLE.
- Reset values: `busy`, `rx_valid`, `crc_error`, `frame_error` and `timeout` are 0; `cmd_index`=0 and `payload`=0.
- Reset mid-frame discards the partial frame with no pulse on any output.

## Timing
- `rx_valid` is high in the cycle after the clock edge that samples the end bit (latency 1 cycle).
- `timeout` is high in the cycle after the edge that samples the `TIMEOUT`-th high strobe.
- `busy` rises in the cycle after `arm` is accepted. It falls in the cycle after DONE or after the `timeout` pulse.
- `arm` and `shift_enable` in the same cycle while in IDLE: the strobe is not sampled.
- `shift_enable` may be asserted on consecutive cycles or sparsely; correctness must not depend on strobe spacing.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sd_pkg`:
  - state enum `sd_rx_state_t`;
  - `SD_FRAME_BITS`=48;
  - `SD_CRC7_POLY`=7'h09.
- Sub-module `sd_crc7`: serial CRC7 with ports `clk`, `rst`, `clear`, `enable`, `bit_in`, `crc[6:0]`. It is shared with the command transmit path.
- The top module contains the FSM, the 6-bit strobe/bit counter, the 47-bit shift register and the output registers.

## Test plan
- Happy path: arm, 3 idle-high strobes, then frame 0x08_000001AA_13 (CMD8 R7) on consecutive strobes.
  - Required: one `rx_valid` pulse with `cmd_index`=8, `payload`=0x000001AA, `crc_error`=0, `frame_error`=0.
- CRC error: same frame with the CRC byte changed to 0x15.
  - Required: `rx_valid` with `crc_error`=1, `frame_error`=0, and `payload` still 0x000001AA.
- Framing and CRC disable: same frame with end bit 0 and `CHECK_CRC`=0.
  - Required: `frame_error`=1 and `crc_error`=0.
- Timeout and ignored arm: arm with `serial_in` held at 1 for 64 strobes.
  - Required: a single `timeout` pulse one cycle after the 64th strobe, then `busy`=0.
  - Required: `arm` pulses issued mid-wait are ignored.
- Sparse strobes and reset mid-frame:
  - Strobes every 3rd cycle: the 0x08_000001AA_13 frame decodes identically to the happy path.
  - `rst` after 20 frame bits, then a full new frame: exactly one `rx_valid`, for the second frame only.
  - `rx_valid`, `busy` and `timeout` read 0 during reset.

Source files
------------

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the SD response receive path
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_DONE
    } sd_rx_state_t;

    localparam int SD_FRAME_BITS = 48;
    localparam logic [6:0] SD_CRC7_POLY = 7'h09;

    // One serial CRC7 step (x^7 + x^3 + 1), MSB-first data
    function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator shared by the command transmit and response receive paths
import sd_pkg::*;

module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    // clear together with enable restarts from zero and absorbs bit_in in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= sd_crc7_step(clear ? 7'h00 : crc, bit_in);
        end else if (clear) begin
            crc <= 7'h00;
        end
    end

endmodule

// File: rtl/sd_resp_rx.sv
// rtl/sd_resp_rx.sv - 48-bit SD response receiver with framing, CRC7 and NCR timeout checks
import sd_pkg::*;

module sd_resp_rx #(
    parameter int TIMEOUT   = 64,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        shift_enable,
    input  logic        serial_in,
    output logic        busy,
    output logic        rx_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] payload,
    output logic        crc_error,
    output logic        frame_error,
    output logic        timeout
);

    localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);
    localparam int         HOLD_W   = SD_FRAME_BITS - 2;

    sd_rx_state_t state, state_next;

    // cnt counts idle strobes in WAIT_START and remaining frame bits in RECEIVE
    logic [5:0]        cnt;
    // Frame bits 46..1 are stored; bit 0 (end bit) is taken live from serial_in on the last strobe,
    // so together they form the 47 bits following the start bit.
    logic [HOLD_W-1:0] shreg;
    logic [46:0]       frame_next;
    logic              timeout_q;
    logic [5:0]        cmd_q;
    logic [31:0]       payload_q;
    logic              crc_err_q;
    logic              frame_err_q;
    logic [6:0]        crc_calc;

    logic start_hit;
    logic tmo_hit;
    logic last_bit;
    logic crc_clear;
    logic crc_enable;

    assign frame_next = {shreg, serial_in};
    assign start_hit  = (state == ST_WAIT_START) && shift_enable && !timeout_q && !serial_in;
    assign tmo_hit    = (state == ST_WAIT_START) && shift_enable && !timeout_q && serial_in
                        && (cnt == TMO_LAST);
    assign last_bit   = (state == ST_RECEIVE) && shift_enable && (cnt == 6'd0);
    assign crc_clear  = start_hit;
    assign crc_enable = start_hit || ((state == ST_RECEIVE) && shift_enable && (cnt >= 6'd8));

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .enable (crc_enable),
        .bit_in (serial_in),
        .crc    (crc_calc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the timeout pulse cycle stays in WAIT_START so busy spans it
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (arm) state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (timeout_q)      state_next = ST_IDLE;
                else if (start_hit) state_next = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (last_bit) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register only
    always_comb begin
        busy     = 1'b0;
        rx_valid = 1'b0;
        busy     = (state != ST_IDLE);
        rx_valid = (state == ST_DONE);
    end

    // Counter, shift register, timeout pulse and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 6'd0;
            shreg       <= '0;
            timeout_q   <= 1'b0;
            cmd_q       <= 6'd0;
            payload_q   <= 32'd0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            timeout_q <= tmo_hit;
            case (state)
                ST_IDLE: begin
                    if (arm) cnt <= 6'd0;
                end
                ST_WAIT_START: begin
                    if (shift_enable && !timeout_q) begin
                        if (!serial_in) cnt <= 6'd46;
                        else            cnt <= cnt + 6'd1;
                    end
                end
                ST_RECEIVE: begin
                    if (shift_enable) begin
                        shreg <= frame_next[HOLD_W-1:0];
                        cnt   <= cnt - 6'd1;
                        if (cnt == 6'd0) begin
                            cmd_q       <= frame_next[45:40];
                            payload_q   <= frame_next[39:8];
                            crc_err_q   <= (CHECK_CRC != 1'b0) && (frame_next[7:1] != crc_calc);
                            frame_err_q <= frame_next[46] || !frame_next[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_index   = cmd_q;
    assign payload     = payload_q;
    assign crc_error   = crc_err_q;
    assign frame_error = frame_err_q;
    assign timeout     = timeout_q;

endmodule
